uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Byte-stream framer that sits directly downstream of `UART_Rx`. It consumes the receiver's per-byte strobe and data, and assembles sync-delimited command frames. It checks each frame's length and XOR checksum, then presents the command and payload to the smartwatch control logic as one registered, single-cycle-valid frame. Malformed or stalled frames are dropped and reported with an error pulse and code.

## Interface
- `MAX_PAYLOAD`, 16: maximum payload bytes per frame, 1..32.
- `TIMEOUT_CLKS`, 21700: inter-byte timeout in clocks; 10 byte times at 217 clks/bit.
- `clk` in 1: system clock, same clock as `UART_Rx`.
- `rst_n` in 1: reset, synchronous, active-low.
- `i_RX_DV` in 1: byte strobe from `UART_Rx`; every high cycle is one byte.
- `i_RX_Byte` in 8: received byte, sampled when `i_RX_DV`=1.
- `o_Frame_DV` out 1: one-cycle pulse when a valid frame is presented.
- `o_Cmd` out 8: command byte of the last valid frame.
- `o_Len` out $clog2(MAX_PAYLOAD+1): payload length of the last valid frame.
- `o_Payload` out MAX_PAYLOAD*8: payload. Byte i is at [8i+7:8i]; bytes at index ≥ `o_Len` are zero.
- `o_Err` out 1: one-cycle pulse when a frame is dropped.
- `o_Err_Code` out 2: cause of the drop, valid with `o_Err`: 01 bad length, 10 checksum, 11 timeout.
- `o_Busy` out 1: high whenever the state is not IDLE.

## Operation
- Frame format: SYNC (0xA5), CMD, LEN, LEN payload bytes, CHK.
- CHK = XOR of CMD, LEN and all payload bytes.
- States and transitions, each advancing on an `i_RX_DV` cycle:
  - IDLE: 0xA5 → CMD. Any other byte is discarded silently with no error.
  - CMD: latch the byte → LEN.
  - LEN: LEN > MAX_PAYLOAD → error 01, go to IDLE. LEN = 0 → CHK. Otherwise → PAYLOAD.
  - PAYLOAD: store the byte at index cnt and increment cnt. On the LEN-th byte → CHK.
  - CHK: byte = running XOR → frame valid; otherwise error 10. Either way → IDLE.
- 0xA5 inside CMD, LEN, PAYLOAD or CHK is ordinary data; there is no resync.
- A byte that causes an error is consumed and is not re-examined as SYNC.
- Working buffer:
  - Cleared on every SYNC acceptance.
  - Copied into the output registers (`o_Cmd`, `o_Len`, `o_Payload`) only when a frame is valid.
  - The output registers hold their values until the next valid frame; errors do not touch them.
- Timeout:
  - The idle counter runs while the state is not IDLE and clears on every `i_RX_DV`.
  - When the count reaches TIMEOUT_CLKS: error 11 and go to IDLE.
  - The counter is held at zero in IDLE.
- If a byte arrives in the same cycle as the timeout terminal count, the byte wins: the counter clears and no timeout is flagged.
- Reset:
  - All outputs go to 0, state to IDLE, and the counter and buffers to 0.
  - Reset mid-frame discards the partial frame and produces no `o_Err`.

## Timing
- All outputs are registered.
- `o_Frame_DV` or `o_Err` goes high in the cycle after the clock edge that samples the deciding `i_RX_DV`, and stays high for exactly one cycle.
- `o_Cmd`, `o_Len` and `o_Payload` change in the same cycle `o_Frame_DV` rises.
- `o_Busy` rises one cycle after SYNC is sampled and falls with the `o_Frame_DV`/`o_Err` cycle.
- Timeout error: `o_Err` rises TIMEOUT_CLKS+1 cycles after the last accepted byte's `i_RX_DV` cycle.
- Back-to-back `i_RX_DV` cycles are all accepted, giving a throughput of 1 byte/clk.
- A new SYNC may arrive in the cycle right after CHK.
- `o_Frame_DV` and `o_Err` are never high in the same cycle.

## Structure
- Package `uart_frame_pkg` holds:
  - `SYNC_BYTE` = 8'hA5.
  - State enum `frame_state_t`: IDLE, CMD, LEN, PAYLOAD, CHK.
  - Error-code enum `frame_err_t`: NONE=00, LEN=01, CHK=10, TMO=11.
- One sub-module, `uart_idle_timer`:
  - Parameter TIMEOUT_CLKS.
  - Inputs: `clk`, `rst_n`, `i_En`, `i_Clr`.
  - Output: one-cycle `o_Expired`.
  - Counter width $clog2(TIMEOUT_CLKS+1), saturating; no wrap.
- The FSM, working buffer and output registers live in `uart_frame_parser`.

## Test plan
- Valid frame A5 10 02 37 05 20 → one `o_Frame_DV` pulse with `o_Cmd`=0x10, `o_Len`=2, `o_Payload`[15:0]=0x0537, upper bytes 0, `o_Err`=0.
- Garbage prefix 00 FF A5 20 00 20 → only one pulse, `o_Cmd`=0x20, `o_Len`=0, no `o_Err`.
- Bad checksum A5 10 02 37 05 21 → `o_Err`=1 with code 10, no `o_Frame_DV`, and outputs still hold the previous frame.
- Bad length A5 10 11 with MAX_PAYLOAD=16 → error 01 immediately after the LEN byte. A following valid frame is accepted.
- Timeout with TIMEOUT_CLKS=100: send A5 10, then stall → `o_Err` code 11 exactly 101 cycles after the 0x10 strobe, then `o_Busy`=0. A byte strobe on the terminal-count cycle suppresses the error.
- Reset plus system loop:
  - Assert `rst_n`=0 mid-payload → all outputs 0 with no pulse, and the next frame parses.
  - Drive through `UART_Rx` at CLKS_PER_BIT=217 with the serialized frame from case 1 → same result as case 1.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared constants and enums for the UART command framer.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CHK
  } frame_state_t;

  // Prefixed so the literals do not collide with the state names.
  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_LEN  = 2'b01,
    ERR_CHK  = 2'b10,
    ERR_TMO  = 2'b11
  } frame_err_t;

endpackage

// File: rtl/uart_frame_parser_timer.sv
// Inter-byte idle timer: counts while enabled, clears on every byte, saturates.
module uart_idle_timer #(
  parameter int TIMEOUT_CLKS = 21700
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_En,
  input  logic i_Clr,
  output logic o_Expired
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0] TERM_COUNT = CW'(TIMEOUT_CLKS);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || !i_En || i_Clr) begin
      count_reg <= '0;
    end else if (count_reg != TERM_COUNT) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Flags the edge on which the count would reach TIMEOUT_CLKS; a byte that cycle wins.
  assign o_Expired = i_En && !i_Clr && (count_reg == LAST_COUNT);

endmodule

// File: rtl/uart_frame_parser.sv
// Sync-delimited frame assembler behind UART_Rx: length, XOR checksum and
// inter-byte timeout checks, with registered single-cycle frame/error reporting.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_PAYLOAD  = 16,
  parameter int TIMEOUT_CLKS = 21700,
  localparam int LW = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_RX_DV,
  input  logic [7:0]               i_RX_Byte,
  output logic                     o_Frame_DV,
  output logic [7:0]               o_Cmd,
  output logic [LW-1:0]            o_Len,
  output logic [MAX_PAYLOAD*8-1:0] o_Payload,
  output logic                     o_Err,
  output logic [1:0]               o_Err_Code,
  output logic                     o_Busy
);

  frame_state_t             state_reg;
  logic [7:0]               cmd_reg;
  logic [7:0]               len_reg;
  logic [7:0]               chk_reg;
  logic [LW-1:0]            cnt_reg;
  logic [MAX_PAYLOAD*8-1:0] buf_flat;
  logic                     expired;
  logic                     sync_accept;
  logic                     store;

  assign sync_accept = i_RX_DV && (state_reg == IDLE) && (i_RX_Byte == SYNC_BYTE);
  assign store       = i_RX_DV && (state_reg == PAYLOAD);
  assign o_Busy      = (state_reg != IDLE);

  uart_idle_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_En     (state_reg != IDLE),
    .i_Clr    (i_RX_DV),
    .o_Expired(expired)
  );

  // Working buffer is wiped on each SYNC so unused bytes always read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_buf
      logic [7:0] byte_reg;
      always_ff @(posedge clk) begin
        if (!rst_n || sync_accept) begin
          byte_reg <= '0;
        end else if (store && (cnt_reg == LW'(gi))) begin
          byte_reg <= i_RX_Byte;
        end
      end
      assign buf_flat[8*gi +: 8] = byte_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cmd_reg    <= '0;
      len_reg    <= '0;
      chk_reg    <= '0;
      cnt_reg    <= '0;
      o_Frame_DV <= 1'b0;
      o_Err      <= 1'b0;
      o_Err_Code <= ERR_NONE;
      o_Cmd      <= '0;
      o_Len      <= '0;
      o_Payload  <= '0;
    end else begin
      o_Frame_DV <= 1'b0;
      o_Err      <= 1'b0;
      if (expired) begin
        o_Err      <= 1'b1;
        o_Err_Code <= ERR_TMO;
        state_reg  <= IDLE;
      end else if (i_RX_DV) begin
        case (state_reg)
          IDLE: begin
            if (i_RX_Byte == SYNC_BYTE) begin
              state_reg <= CMD;
              cmd_reg   <= '0;
              len_reg   <= '0;
              chk_reg   <= '0;
              cnt_reg   <= '0;
            end
          end
          CMD: begin
            cmd_reg   <= i_RX_Byte;
            chk_reg   <= chk_reg ^ i_RX_Byte;
            state_reg <= LEN;
          end
          LEN: begin
            len_reg <= i_RX_Byte;
            chk_reg <= chk_reg ^ i_RX_Byte;
            if (i_RX_Byte > 8'(MAX_PAYLOAD)) begin
              o_Err      <= 1'b1;
              o_Err_Code <= ERR_LEN;
              state_reg  <= IDLE;
            end else if (i_RX_Byte == 8'd0) begin
              state_reg <= CHK;
            end else begin
              state_reg <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            cnt_reg <= cnt_reg + LW'(1);
            chk_reg <= chk_reg ^ i_RX_Byte;
            if ((8'(cnt_reg) + 8'd1) == len_reg) begin
              state_reg <= CHK;
            end
          end
          CHK: begin
            if (i_RX_Byte == chk_reg) begin
              o_Frame_DV <= 1'b1;
              o_Cmd      <= cmd_reg;
              o_Len      <= LW'(len_reg);
              o_Payload  <= buf_flat;
            end else begin
              o_Err      <= 1'b1;
              o_Err_Code <= ERR_CHK;
            end
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed frames plus randomized traffic
// checked against a frame-level reference model.
module tb_uart_frame_parser;

  localparam int MAXP = 16;
  localparam int T    = 100;

  typedef struct {
    bit           is_err;
    logic [1:0]   code;
    logic [7:0]   cmd;
    logic [4:0]   len;
    logic [127:0] pl;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_dv;
  logic [7:0]   rx_byte;
  logic         o_Frame_DV;
  logic [7:0]   o_Cmd;
  logic [4:0]   o_Len;
  logic [127:0] o_Payload;
  logic         o_Err;
  logic [1:0]   o_Err_Code;
  logic         o_Busy;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_cyc = 0;

  exp_t         sb_q[$];
  exp_t         mon_e;
  logic [7:0]   tx_q[$];
  logic [7:0]   last_cmd = 8'h00;
  logic [4:0]   last_len = 5'd0;
  logic [127:0] last_pl  = '0;
  logic [7:0]   f_cmd;
  logic [4:0]   f_len;
  logic [127:0] f_pl;

  uart_frame_parser #(
    .MAX_PAYLOAD (MAXP),
    .TIMEOUT_CLKS(T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_RX_DV   (rx_dv),
    .i_RX_Byte (rx_byte),
    .o_Frame_DV(o_Frame_DV),
    .o_Cmd     (o_Cmd),
    .o_Len     (o_Len),
    .o_Payload (o_Payload),
    .o_Err     (o_Err),
    .o_Err_Code(o_Err_Code),
    .o_Busy    (o_Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a frame or an error.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      mon_e = sb_q.pop_front();
      check("missing_event_cycle", 128'(cyc), 128'(mon_e.cyc));
    end
    if (o_Frame_DV || o_Err) begin
      check("dv_err_exclusive", 128'(o_Frame_DV & o_Err), 128'(0));
      if (sb_q.size() == 0) begin
        check("unexpected_event", 128'({o_Frame_DV, o_Err}), 128'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check("event_is_err", 128'(o_Err), 128'(mon_e.is_err));
        check("event_cycle", 128'(cyc), 128'(mon_e.cyc));
        if (mon_e.is_err) check("err_code", 128'(o_Err_Code), 128'(mon_e.code));
        check("cmd", 128'(o_Cmd), 128'(mon_e.cmd));
        check("len", 128'(o_Len), 128'(mon_e.len));
        check("payload", o_Payload, mon_e.pl);
        check("busy_at_event", 128'(o_Busy), 128'(0));
        $display("event %s code=%0d cmd=%02h len=%0d cycle=%0d",
                 o_Err ? "err" : "frame", o_Err_Code, o_Cmd, o_Len, cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_dv = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    @(negedge clk);
    rx_dv    = 1'b1;
    rx_byte  = b;
    last_cyc = cyc;
  endtask

  function automatic int rand_gap();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return T - 1;
    if (r < 10) return 0;
    return $urandom_range(1, 3);
  endfunction

  task automatic send_q(input bit rand_gaps);
    foreach (tx_q[i]) send_byte(tx_q[i], rand_gaps ? rand_gap() : 0);
  endtask

  // Reference model: frame contents and expected outcome derived from the frame rules.
  task automatic make_frame(input int len, input bit bad);
    logic [7:0] x;
    logic [7:0] b;
    tx_q.delete();
    f_cmd = 8'($urandom);
    f_len = 5'(len);
    f_pl  = '0;
    x = f_cmd ^ 8'(len);
    tx_q.push_back(8'hA5);
    tx_q.push_back(f_cmd);
    tx_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      f_pl[8*i +: 8] = b;
      x = x ^ b;
      tx_q.push_back(b);
    end
    if (bad) x = x ^ 8'($urandom_range(1, 255));
    tx_q.push_back(x);
  endtask

  task automatic push_frame(input logic [7:0] c, input logic [4:0] l, input logic [127:0] p);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'b00; e.cmd = c; e.len = l; e.pl = p;
    e.cyc = last_cyc + 1;
    sb_q.push_back(e);
    last_cmd = c; last_len = l; last_pl = p;
  endtask

  task automatic push_err(input logic [1:0] code, input int delay);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.cmd = last_cmd; e.len = last_len; e.pl = last_pl;
    e.cyc = last_cyc + delay;
    sb_q.push_back(e);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d events pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int m;
    logic [7:0] g;
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
    idle(3);
    check("rst_cmd", 128'(o_Cmd), 128'(0));
    check("rst_len", 128'(o_Len), 128'(0));
    check("rst_payload", o_Payload, 128'(0));
    check("rst_flags", 128'({o_Frame_DV, o_Err, o_Err_Code, o_Busy}), 128'(0));
    rst_n = 1'b1;
    idle(2);

    // Valid two-byte frame.
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h37, 8'h05, 8'h20};
    send_q(0); push_frame(8'h10, 5'd2, 128'h0537); idle(2);
    // Garbage prefix, zero-length frame.
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h20, 8'h00, 8'h20};
    send_q(0); push_frame(8'h20, 5'd0, 128'h0); idle(2);
    // Bad checksum leaves previous frame on the outputs.
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h37, 8'h05, 8'h21};
    send_q(0); push_err(2'b10, 1); idle(2);
    // Bad length, then a valid frame immediately after.
    tx_q = '{8'hA5, 8'h10, 8'h11};
    send_q(0); push_err(2'b01, 1);
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h37, 8'h05, 8'h20};
    send_q(0); push_frame(8'h10, 5'd2, 128'h0537);
    // Length byte equal to SYNC is consumed as an error.
    tx_q = '{8'hA5, 8'h10, 8'hA5};
    send_q(0); push_err(2'b01, 1); idle(2);
    // Stall after CMD: timeout.
    tx_q = '{8'hA5, 8'h10};
    send_q(0); push_err(2'b11, T + 1); idle(T + 5);
    check("busy_after_timeout", 128'(o_Busy), 128'(0));
    // Bytes landing exactly on the terminal-count cycle keep the frame alive.
    send_byte(8'hA5, 0);
    @(negedge clk); rx_dv = 1'b0;
    check("busy_after_sync", 128'(o_Busy), 128'(1));
    send_byte(8'h10, T - 2);
    send_byte(8'h02, T - 1);
    send_byte(8'h37, T - 1);
    send_byte(8'h05, 0);
    send_byte(8'h20, T - 1);
    push_frame(8'h10, 5'd2, 128'h0537); idle(2);
    // Reset mid-payload: no error, outputs cleared, next frame parses.
    make_frame(8, 0);
    for (int i = 0; i < 6; i++) send_byte(tx_q[i], 0);
    @(negedge clk); rst_n = 1'b0; rx_dv = 1'b0;
    @(negedge clk);
    check("midrst_cmd", 128'(o_Cmd), 128'(0));
    check("midrst_len", 128'(o_Len), 128'(0));
    check("midrst_payload", o_Payload, 128'(0));
    check("midrst_flags", 128'({o_Frame_DV, o_Err, o_Busy}), 128'(0));
    rst_n = 1'b1;
    last_cmd = 8'h00; last_len = 5'd0; last_pl = '0;
    tx_q = '{8'hA5, 8'h10, 8'h02, 8'h37, 8'h05, 8'h20};
    send_q(0); push_frame(8'h10, 5'd2, 128'h0537); idle(2);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do g = 8'($urandom); while (g == 8'hA5);
        send_byte(g, rand_gap());
      end
      kind = $urandom_range(0, 9);
      case (kind)
        0: begin
          do g = 8'($urandom); while (g == 8'hA5);
          send_byte(g, rand_gap());
        end
        1: begin
          make_frame($urandom_range(0, MAXP), 1);
          send_q(1); push_err(2'b10, 1);
        end
        2: begin
          tx_q = '{8'hA5, 8'($urandom), 8'($urandom_range(MAXP + 1, 255))};
          send_q(1); push_err(2'b01, 1);
        end
        3: begin
          make_frame($urandom_range(0, MAXP), 0);
          m = $urandom_range(1, tx_q.size() - 1);
          while (tx_q.size() > m) void'(tx_q.pop_back());
          send_q(1); push_err(2'b11, T + 1); idle(T + 3);
        end
        default: begin
          make_frame($urandom_range(0, MAXP), 0);
          send_q(1); push_frame(f_cmd, f_len, f_pl);
        end
      endcase
    end

    idle(2 * T);
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
